// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller: double-buffered digit frame,
// one-hot digit enables with blanking gaps, and leading-zero suppression.
module seg_scan_ctrl #(
  parameter int          NUM_DIGITS   = 4,
  parameter logic [15:0] SCAN_DIV     = 16'd25,
  parameter int          BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ena,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [5*NUM_DIGITS-1:0] load_data,
  input  logic                    lzs_en,
  output logic [4:0]              dec_code,
  output logic                    seg_blank,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done,
  output logic                    busy
);

  localparam int              IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [15:0]     BLANK_LAST = 16'(BLANK_CYCLES - 1);
  localparam logic [15:0]     DRIVE_LAST = SCAN_DIV - 16'd1;

  typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_DRIVE} state_t;

  state_t                       r_state, w_state_nx;
  logic [IDX_W-1:0]             r_idx, w_idx_nx;
  logic [15:0]                  r_cnt, w_cnt_nx;
  logic                         w_boundary;
  logic [NUM_DIGITS-1:0][4:0]   r_active, r_shadow;
  logic                         r_pending;
  logic                         w_take;
  logic [NUM_DIGITS-1:0]        w_zero_above;
  logic [NUM_DIGITS-1:0]        w_digit_en_nx;
  logic [4:0]                   w_dec_code_nx;
  logic                         w_seg_blank_nx;
  logic                         w_frame_done_nx;

  // Bit i is set when digit i and every more-significant digit hold code 0.
  function automatic logic [NUM_DIGITS-1:0] f_zero_above(
    input logic [NUM_DIGITS-1:0][4:0] frame
  );
    logic acc;
    f_zero_above = '0;
    acc          = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      acc             = acc & (frame[i] == 5'd0);
      f_zero_above[i] = acc;
    end
  endfunction

  assign load_ready   = !r_pending;
  assign w_take       = load_valid && !r_pending;
  assign w_zero_above = f_zero_above(r_active);

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_cnt_nx   = r_cnt;
    w_boundary = 1'b0;
    if (!ena) begin
      w_state_nx = ST_IDLE;
      w_idx_nx   = '0;
      w_cnt_nx   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nx = ST_BLANK;
          w_idx_nx   = '0;
          w_cnt_nx   = '0;
          w_boundary = 1'b1;
        end
        ST_BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            w_state_nx = ST_DRIVE;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = r_cnt + 16'd1;
          end
        end
        ST_DRIVE: begin
          if (r_cnt == DRIVE_LAST) begin
            w_state_nx = ST_BLANK;
            w_cnt_nx   = '0;
            if (r_idx == LAST_IDX) begin
              w_idx_nx   = '0;
              w_boundary = 1'b1;
            end else begin
              w_idx_nx = r_idx + 1'b1;
            end
          end else begin
            w_cnt_nx = r_cnt + 16'd1;
          end
        end
        default: w_state_nx = ST_IDLE;
      endcase
    end
  end

  // NOTE: outputs are decoded from the next state and registered, so they line
  // up with the state register without a combinational path to the pads.
  always_comb begin
    w_digit_en_nx   = '0;
    w_dec_code_nx   = '0;
    w_seg_blank_nx  = 1'b1;
    w_frame_done_nx = 1'b0;
    if (w_state_nx == ST_DRIVE) begin
      w_digit_en_nx   = NUM_DIGITS'(1) << w_idx_nx;
      w_dec_code_nx   = r_active[w_idx_nx];
      w_seg_blank_nx  = lzs_en && (w_idx_nx != '0) && w_zero_above[w_idx_nx];
      w_frame_done_nx = (w_idx_nx == LAST_IDX) && (w_cnt_nx == DRIVE_LAST);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_en   <= '0;
      dec_code   <= '0;
      seg_blank  <= 1'b1;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      digit_en   <= w_digit_en_nx;
      dec_code   <= w_dec_code_nx;
      seg_blank  <= w_seg_blank_nx;
      frame_done <= w_frame_done_nx;
      busy       <= (w_state_nx != ST_IDLE);
    end
  end

  // Shadow is written only while empty; it moves to active only at frame boundaries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_active  <= '0;
      r_shadow  <= '0;
      r_pending <= 1'b0;
    end else if (w_boundary && r_pending) begin
      r_active  <= r_shadow;
      r_pending <= 1'b0;
    end else if (w_take) begin
      r_shadow  <= load_data;
      r_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYCLES=2:
// each frame is 24 cycles, digit d is blanked at positions 6d..6d+1 and driven at 6d+2..6d+5.
module tb_seg_scan_ctrl;

  localparam logic [19:0] FRAME_B = 20'h0C8A3;  // d3..d0 = 1,18,5,3
  localparam logic [19:0] FRAME_C = 20'h000E0;  // d3..d0 = 0,0,7,0
  localparam logic [19:0] FRAME_E = 20'h110C8;  // d3..d0 = 2,4,6,8

  logic        clk = 1'b0;
  logic        reset;
  logic        ena;
  logic        load_valid;
  logic        load_ready;
  logic [19:0] load_data;
  logic        lzs_en;
  logic [4:0]  dec_code;
  logic        seg_blank;
  logic [3:0]  digit_en;
  logic        frame_done;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .NUM_DIGITS  (4),
    .SCAN_DIV    (16'd4),
    .BLANK_CYCLES(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ena       (ena),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_data (load_data),
    .lzs_en    (lzs_en),
    .dec_code  (dec_code),
    .seg_blank (seg_blank),
    .digit_en  (digit_en),
    .frame_done(frame_done),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_digit_en"},   32'(digit_en),   32'd0);
    check({tag, "_dec_code"},   32'(dec_code),   32'd0);
    check({tag, "_seg_blank"},  32'(seg_blank),  32'd1);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_busy"},       32'(busy),       32'd0);
  endtask

  // Expected outputs at position p (0..23) of a frame showing 'frame'.
  task automatic expect_pos(input int p, input logic [19:0] frame, input logic lzs,
                            input logic rdy);
    int         d;
    int         ph;
    logic       drive;
    logic [4:0] code;
    logic [3:0] en;
    logic       blank;
    logic       fd;
    d     = p / 6;
    ph    = p % 6;
    drive = (ph >= 2);
    code  = drive ? frame[5*d +: 5] : 5'd0;
    en    = drive ? 4'(1 << d) : 4'b0000;
    blank = drive ? (lzs && (d > 0) && ((frame >> (5*d)) == 20'd0)) : 1'b1;
    fd    = (d == 3) && (ph == 5);
    check($sformatf("digit_en@%0d", p),   32'(digit_en),   32'(en));
    check($sformatf("dec_code@%0d", p),   32'(dec_code),   32'(code));
    check($sformatf("seg_blank@%0d", p),  32'(seg_blank),  32'(blank));
    check($sformatf("frame_done@%0d", p), 32'(frame_done), 32'(fd));
    check($sformatf("busy@%0d", p),       32'(busy),       32'd1);
    check($sformatf("load_ready@%0d", p), 32'(load_ready), 32'(rdy));
  endtask

  initial begin
    reset      = 1'b1;
    ena        = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    lzs_en     = 1'b0;
    repeat (3) tick();
    check_reset_outputs("por");
    check("por_load_ready", 32'(load_ready), 32'd1);

    @(negedge clk);
    reset = 1'b0;
    tick();
    check_reset_outputs("idle");

    // Frame 1: empty frame, plain scan sequence.
    ena = 1'b1;
    tick();
    for (int p = 0; p < 24; p++) begin
      expect_pos(p, 20'h0, 1'b0, 1'b1);
      tick();
    end

    // Frame 2: load B mid-frame, then hold C on the bus while B is pending.
    for (int p = 0; p < 24; p++) begin
      expect_pos(p, 20'h0, 1'b0, p <= 8);
      if (p == 8) begin
        load_valid = 1'b1;
        load_data  = FRAME_B;
      end else if (p == 9) begin
        load_data = FRAME_C;
      end
      tick();
    end

    // Frame 3: B shown; C captured right after the boundary.
    for (int p = 0; p < 24; p++) begin
      expect_pos(p, FRAME_B, 1'b0, p == 0);
      if (p == 1) begin
        load_valid = 1'b0;
        load_data  = '0;
      end
      tick();
    end

    // Frame 4: C with leading-zero suppression; queue an all-zero frame.
    lzs_en = 1'b1;
    for (int p = 0; p < 24; p++) begin
      expect_pos(p, FRAME_C, 1'b1, p <= 3);
      if (p == 3) begin
        load_valid = 1'b1;
        load_data  = 20'h0;
      end else if (p == 4) begin
        load_valid = 1'b0;
      end
      tick();
    end

    // Frame 5: all zero, only digit 0 unblanked; queue E, drop ena in digit 2.
    for (int p = 0; p < 16; p++) begin
      expect_pos(p, 20'h0, 1'b1, p <= 1);
      if (p == 1) begin
        load_valid = 1'b1;
        load_data  = FRAME_E;
      end else if (p == 2) begin
        load_valid = 1'b0;
      end else if (p == 15) begin
        ena = 1'b0;
      end
      tick();
    end
    check_reset_outputs("ena_off");
    check("ena_off_load_ready", 32'(load_ready), 32'd0);
    repeat (2) tick();
    check("idle_hold_busy", 32'(busy), 32'd0);
    check("idle_hold_load_ready", 32'(load_ready), 32'd0);

    // Frame 6: re-enable applies the pending frame from digit 0.
    ena = 1'b1;
    tick();
    for (int p = 0; p < 24; p++) begin
      expect_pos(p, FRAME_E, 1'b1, 1'b1);
      tick();
    end

    // Frame 7: queue B, then assert reset during digit 1 drive.
    lzs_en = 1'b0;
    for (int p = 0; p <= 10; p++) begin
      expect_pos(p, FRAME_E, 1'b0, p == 0);
      if (p == 0) begin
        load_valid = 1'b1;
        load_data  = FRAME_B;
      end else if (p == 1) begin
        load_valid = 1'b0;
      end
      if (p < 10) tick();
    end
    reset = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    check("async_rst_load_ready", 32'(load_ready), 32'd1);

    // Frame 8: after reset the active frame is zero and B was discarded.
    @(negedge clk);
    reset = 1'b0;
    tick();
    for (int p = 0; p < 24; p++) begin
      expect_pos(p, 20'h0, 1'b0, 1'b1);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
